// File: rtl/branch_hazard_stall.sv
// Stall/flush controller for ID-resolved branches: detects hazards forwarding cannot cover.
// Latency: control outputs are combinational (0 cycles); counters update on the rising edge.
// Backpressure: on a hazard, PC and IF/ID are frozen and ID/EX takes bubbles for 1 or 2 cycles.
module branch_hazard_stall #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_branch,
    input  logic                  id_taken,
    input  logic [REG_ADDR_W-1:0] ex_wrreg,
    input  logic                  ex_regwr,
    input  logic                  ex_memrd,
    input  logic [REG_ADDR_W-1:0] mem_wrreg,
    input  logic                  mem_memrd,
    input  logic                  cnt_clr,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic                  ifid_flush,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       ex_match;
    logic       mem_match;
    logic [1:0] need_n;
    logic       stall;
    logic       flush;

    // Producer-register matches against the ID operands; r0 never matches
    always_comb begin
        ex_match  = (ex_wrreg != '0) &&
                    ((ex_wrreg == id_rs) || (id_uses_rt && (ex_wrreg == id_rt)));
        mem_match = (mem_wrreg != '0) &&
                    ((mem_wrreg == id_rs) || (id_uses_rt && (mem_wrreg == id_rt)));
    end

    // Required stall length; a branch waiting on a load in EX dominates everything else
    always_comb begin
        need_n = 2'd0;
        if (id_branch && ex_memrd && ex_match) begin
            need_n = 2'd2;
        end else if ((id_branch && ex_regwr && !ex_memrd && ex_match) ||
                     (id_branch && mem_memrd && mem_match) ||
                     (!id_branch && ex_memrd && ex_match)) begin
            need_n = 2'd1;
        end
    end

    // State register: IDLE evaluates hazards, HOLD covers the extra cycle of a 2-cycle stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic; HOLD ignores the ID/EX/MEM inputs entirely
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (need_n == 2'd2) begin
                    state_d = HOLD;
                    rem_d   = 1'b0;
                end
            end
            HOLD: begin
                if (rem_q == 1'b0) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = 1'b0;
            end
        endcase
    end

    // Output logic: Mealy stall, gated so reset forces the free-running values
    always_comb begin
        stall       = rst_n && (((state_q == IDLE) && (need_n != 2'd0)) || (state_q == HOLD));
        flush       = rst_n && id_branch && id_taken && !stall;
        pc_write    = !stall;
        ifid_write  = !stall;
        idex_bubble = stall;
        ifid_flush  = flush;
    end

    // Counter next values: clear wins, otherwise saturating increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_branch_hazard_stall.sv
// Randomized plus directed bench for branch_hazard_stall against a cycle-count reference model.
// Latency: outputs checked mid-cycle, counters checked just after each rising edge.
// Backpressure: model tracks remaining forced stall cycles rather than FSM states.
module tb_branch_hazard_stall;

    localparam int RW      = 5;
    localparam int CW      = 5;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [RW-1:0] id_rs, id_rt, ex_wrreg, mem_wrreg;
    logic          id_uses_rt, id_branch, id_taken, ex_regwr, ex_memrd, mem_memrd, cnt_clr;
    logic          pc_write, ifid_write, idex_bubble, ifid_flush;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int hold_left = 0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;

    branch_hazard_stall #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_taken(id_taken),
        .ex_wrreg(ex_wrreg), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd),
        .mem_wrreg(mem_wrreg), .mem_memrd(mem_memrd), .cnt_clr(cnt_clr),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit mt(input logic [RW-1:0] r);
        return (r != 0) && ((r == id_rs) || (id_uses_rt && (r == id_rt)));
    endfunction

    function automatic int need_cycles();
        int n = 0;
        if (id_branch && ex_memrd && mt(ex_wrreg)) n = 2;
        if (id_branch && ex_regwr && !ex_memrd && mt(ex_wrreg) && n < 1) n = 1;
        if (id_branch && mem_memrd && mt(mem_wrreg) && n < 1) n = 1;
        if (!id_branch && ex_memrd && mt(ex_wrreg) && n < 1) n = 1;
        return n;
    endfunction

    task automatic set_in(input int rs, input int rt, input bit urt, input bit br, input bit tk,
                          input int exw, input bit exrw, input bit exmr,
                          input int mw, input bit mmr, input bit clr);
        id_rs = rs[RW-1:0]; id_rt = rt[RW-1:0]; id_uses_rt = urt;
        id_branch = br; id_taken = tk;
        ex_wrreg = exw[RW-1:0]; ex_regwr = exrw | exmr; ex_memrd = exmr;
        mem_wrreg = mw[RW-1:0]; mem_memrd = mmr; cnt_clr = clr;
    endtask

    task automatic nop_in();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check combinational outputs, advance the model, check counters after the edge
    task automatic cycle();
        int  n;
        bit  e_stall, e_flush;
        @(negedge clk);
        n       = need_cycles();
        e_stall = (hold_left > 0) || (n > 0);
        e_flush = id_branch && id_taken && !e_stall;
        chk("pc_write",    pc_write,    !e_stall);
        chk("ifid_write",  ifid_write,  !e_stall);
        chk("idex_bubble", idex_bubble, e_stall);
        chk("ifid_flush",  ifid_flush,  e_flush);
        if (hold_left > 0) hold_left--;
        else if (n == 2) hold_left = 1;
        if (cnt_clr) begin
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (e_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (e_flush && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        end
        @(posedge clk);
        #1;
        chk("stall_cnt", stall_cnt, m_stall_cnt);
        chk("flush_cnt", flush_cnt, m_flush_cnt);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        #1;
        chk("rst_pc_write",    pc_write,    1);
        chk("rst_ifid_write",  ifid_write,  1);
        chk("rst_idex_bubble", idex_bubble, 0);
        chk("rst_ifid_flush",  ifid_flush,  0);
        chk("rst_stall_cnt",   stall_cnt,   0);
        chk("rst_flush_cnt",   flush_cnt,   0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        nop_in();
        #2;
        do_reset();

        // 1: branch on rs=3 with ALU producer in EX -> one stall, then clear
        set_in(3, 0, 0, 1, 0, 3, 1, 0, 0, 0, 0);
        cycle();
        set_in(3, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0);
        cycle();
        chk("s1_stall_cnt", stall_cnt, 1);

        // 2: branch on rt=5 with load in EX -> two stall cycles (second is HOLD)
        set_in(1, 5, 1, 1, 0, 5, 1, 1, 0, 0, 0);
        cycle();
        cycle();
        nop_in();
        cycle();
        chk("s2_stall_cnt", stall_cnt, 3);

        // 3: load-use on rs=7, then same with r0 producer
        set_in(7, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        cycle();
        chk("s3_stall_cnt", stall_cnt, 4);

        // 4: taken branch, no hazard; then taken branch behind a load
        set_in(2, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("s4_flush_cnt", flush_cnt, 1);
        set_in(2, 4, 1, 1, 1, 4, 1, 1, 0, 0, 0);
        cycle();
        cycle();
        set_in(2, 4, 1, 1, 1, 0, 0, 0, 4, 0, 0);
        cycle();
        chk("s4b_flush_cnt", flush_cnt, 2);

        // 5: reset asserted during HOLD abandons the stall
        set_in(1, 5, 1, 1, 0, 5, 1, 1, 0, 0, 0);
        cycle();
        do_reset();
        nop_in();
        cycle();

        // 6: saturate stall_cnt, then clear concurrent with a stall
        set_in(7, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
        for (int i = 0; i < CNT_MAX + 6; i++) cycle();
        chk("s6_sat", stall_cnt, CNT_MAX);
        cnt_clr = 1'b1;
        cycle();
        chk("s6_clr", stall_cnt, 0);
        nop_in();

        // Random traffic over a small register range so matches are frequent
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 2) == 0),
                   $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 40) == 0));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
